// File: rtl/gx_pkg.sv
// -----------------------------------------------------------------------------
// gx_pkg
// Shared constants, types and helpers for the GX register-write dispatcher.
//   GX_UNIT_XF/BP/CP : destination unit indices
//   GX_STAT_W        : width of each per-unit statistics counter
//   gx_stat_t        : statistics counter type
//   gx_sat_inc()     : saturating counter increment
// Optional feature macro used by the dispatcher: GX_REG_DISPATCH_STATS_EN
// -----------------------------------------------------------------------------
package gx_pkg;

   localparam int GX_UNIT_XF = 0;
   localparam int GX_UNIT_BP = 1;
   localparam int GX_UNIT_CP = 2;

   localparam int GX_STAT_W  = 16;

   typedef logic [GX_STAT_W-1:0] gx_stat_t;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic gx_stat_t gx_sat_inc(input gx_stat_t v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/gx_sync_fifo.sv
// -----------------------------------------------------------------------------
// gx_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rdata whenever empty is low. Storage is not reset; only the pointers are.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : write request (ignored when full) and write data
//   pop          : consume head entry (ignored when empty)
//   rdata        : head entry
//   empty, full  : occupancy flags derived from the pointers
// -----------------------------------------------------------------------------
module gx_sync_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Pointers carry one extra wrap bit: equal means empty, wrap bits
   // differing with equal index bits means full.
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

   // Storage write; no reset on the RAM, and a reset edge writes nothing.
   always_ff @(posedge clk) begin
      if (do_push_s && !reset) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

   // Write and read pointers with natural wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

endmodule

// File: rtl/gx_reg_dispatch.sv
// -----------------------------------------------------------------------------
// gx_reg_dispatch
// Routes upstream register writes {addr,data} into one FWFT queue per
// destination unit. Units drain independently with their own ready bits.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready           : upstream handshake
//   in_unit/in_addr/in_data     : destination unit, register address, data
//   out_valid/out_ready         : per-unit downstream handshake (bit u = unit u)
//   out_addr/out_data           : per-unit head entry, unit u at slice u
//   busy                        : any unit queue holds an entry
//   err_bad_unit                : sticky, set by an accepted write to a
//                                 unit index >= NUM_UNITS
//   stat_clear/stat_count       : per-unit accepted-write counters
// Optional feature: define GX_REG_DISPATCH_STATS_EN to build the saturating
// statistics counters; otherwise stat_count is tied to zero.
// -----------------------------------------------------------------------------
module gx_reg_dispatch
   import gx_pkg::*;
#(
   parameter  int NUM_UNITS  = 3,
   parameter  int DEPTH      = 4,
   parameter  int ADDR_WIDTH = 16,
   parameter  int DATA_WIDTH = 32,
   localparam int UW         = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [UW-1:0]                     in_unit,
   input  logic [ADDR_WIDTH-1:0]             in_addr,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic [NUM_UNITS-1:0]              out_valid,
   input  logic [NUM_UNITS-1:0]              out_ready,
   output logic [NUM_UNITS*ADDR_WIDTH-1:0]   out_addr,
   output logic [NUM_UNITS*DATA_WIDTH-1:0]   out_data,
   output logic                              busy,
   output logic                              err_bad_unit,
   input  logic                              stat_clear,
   output logic [NUM_UNITS*GX_STAT_W-1:0]    stat_count
);

   localparam int             EW          = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [UW:0]    NUM_UNITS_W = NUM_UNITS[UW:0];

   logic [NUM_UNITS-1:0] unit_hit_s;
   logic [NUM_UNITS-1:0] full_s;
   logic [NUM_UNITS-1:0] empty_s;
   logic [NUM_UNITS-1:0] push_s;
   logic [NUM_UNITS-1:0] pop_s;
   logic                 bad_unit_s;
   logic                 accept_s;
   logic                 err_bad_unit_r;

   // Out-of-range units are always accepted (and dropped), so in_ready only
   // looks at the selected queue's full flag, never at out_ready.
   assign bad_unit_s = ({1'b0, in_unit} >= NUM_UNITS_W);
   assign in_ready   = bad_unit_s | ~(|(full_s & unit_hit_s));
   assign accept_s   = in_valid & in_ready;
   assign push_s     = unit_hit_s & {NUM_UNITS{accept_s}};
   assign out_valid  = ~empty_s;
   assign pop_s      = out_valid & out_ready;
   assign busy       = |out_valid;
   assign err_bad_unit = err_bad_unit_r;

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
      logic [EW-1:0] head_s;

      assign unit_hit_s[u] = (in_unit == UW'(u));

      gx_sync_fifo #(
         .WIDTH (EW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push_s[u]),
         .wdata ({in_addr, in_data}),
         .pop   (pop_s[u]),
         .rdata (head_s),
         .empty (empty_s[u]),
         .full  (full_s[u])
      );

      assign out_addr[u*ADDR_WIDTH +: ADDR_WIDTH] = head_s[EW-1 -: ADDR_WIDTH];
      assign out_data[u*DATA_WIDTH +: DATA_WIDTH] = head_s[DATA_WIDTH-1:0];
   end

   // Sticky flag for writes aimed at a unit that does not exist.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_bad_unit_r <= 1'b0;
      end else if (accept_s && bad_unit_s) begin
         err_bad_unit_r <= 1'b1;
      end else begin
         err_bad_unit_r <= err_bad_unit_r;
      end
   end

`ifdef GX_REG_DISPATCH_STATS_EN
   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_stat
      gx_stat_t cnt_r;

      // Per-unit accepted-write counter; clear wins over a same-cycle push.
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_r <= {GX_STAT_W{1'b0}};
         end else if (stat_clear) begin
            cnt_r <= {GX_STAT_W{1'b0}};
         end else if (push_s[u]) begin
            cnt_r <= gx_sat_inc(cnt_r);
         end else begin
            cnt_r <= cnt_r;
         end
      end

      assign stat_count[u*GX_STAT_W +: GX_STAT_W] = cnt_r;
   end
`else
   logic unused_stat_clear_s;

   assign unused_stat_clear_s = stat_clear;
   assign stat_count          = {(NUM_UNITS*GX_STAT_W){1'b0}};
`endif

endmodule
